flobuffer_multi: RTL and testbench
==================================

Name: flobuffer_multi

Overview:
- Parametrised successor to the single-channel delay buffer.
- Queues {delay, data} words in a DEPTH-entry FIFO and replays each word as a one-cycle strobe after its programmed delay.
- Generalised in data width, delay width and depth. Adds async reset, flush, occupancy/busy reporting and defined overflow and direct-write priority rules.
- Sits between the instruction decoder and one output channel (gradient/RF/TX-gate data path).

Parameters:
- DATA_W, 16, width of data_i/data_o.
- DELAY_W, 7, width of delay_i and the internal delay counter.
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_i  in  DATA_W  write data.
- delay_i  in  DELAY_W  cycles to wait before this word is strobed out.
- valid_i  in  1  push {delay_i,data_i} this cycle.
- direct_i  in  1  bypass: present data_i on data_o next cycle.
- flush_i  in  1  discard FIFO contents and abort the pending delay.
- data_o  out  DATA_W  output data, held between strobes.
- stb_o  out  1  single-cycle strobe when data_o updates.
- empty_o  out  1  FIFO holds no entries.
- full_o  out  1  FIFO holds DEPTH entries.
- err_o  out  1  single-cycle strobe when a push is rejected.
- level_o  out  $clog2(DEPTH+1)  current FIFO occupancy.
- busy_o  out  1  output engine not in IDLE.

Behaviour:
- Reset (async assert, sync-released domain):
  - Outputs: data_o=0, stb_o=0, empty_o=1, full_o=0, err_o=0, level_o=0, busy_o=0.
  - Internal: pointers=0, state=IDLE, delay counter=0.
  - Reset mid-WAIT discards the pending word with no strobe.
- Status outputs: all registered. empty_o/full_o/level_o reflect the count after that edge's push/pop.
- Push:
  - Accepted iff valid_i & !full_o & !flush_i. The entry is written at the sampling edge.
  - Rejected iff valid_i & full_o & !flush_i. Data is dropped, err_o=1 for the following cycle, and the FIFO is unchanged.
  - A pop in the same cycle does NOT rescue a rejected push (decision made on registered full_o).
- Pointers: log2(DEPTH) bits, wrap naturally. Occupancy counter is $clog2(DEPTH+1) bits and distinguishes full from empty.
- Output engine FSM:
  - IDLE: if level_o!=0 -> LOAD.
  - LOAD: pop the head entry (d = head delay).
    - d==0: data_o<=data, stb_o=1 next cycle. Stay in LOAD if the post-pop count (including a same-cycle push) is nonzero, else go to IDLE.
    - d!=0: hold the data, counter<=d, go to WAIT.
  - WAIT: counter decrements each cycle. When counter==1: data_o<=held data, stb_o=1. Go to LOAD if count!=0, else IDLE.
  - Timing: strobe spacing between back-to-back queued words is delay+1 cycles.
  - Latency: a delay-0 push into an empty, IDLE buffer strobes 2 cycles after the valid_i edge.
- Flush: highest priority below rst.
  - Pointers, count and counter are cleared; state goes to IDLE.
  - No stb_o is generated from the FIFO that cycle; data_o is held. A push coinciding with flush is dropped silently (no err_o).
- Direct path:
  - direct_i registers data_i; next cycle data_o<=that value and stb_o=1.
  - If a scheduled strobe falls on the same cycle, the direct value wins on data_o and the scheduled word is consumed (lost). Only one stb_o pulse is produced.
  - direct_i does not touch the FIFO. valid_i and direct_i in the same cycle both act.
- busy_o = (state!=IDLE). empty_o can be 1 while busy_o=1 (last word in WAIT).
- Max delay (all ones) is legal: it gives 2^DELAY_W cycles between strobes, with no counter wrap.

Test Plan:
- Delay-0 single push into empty FIFO: push 0x1234 at cycle 0 -> stb_o=1, data_o=0x1234 at cycle 2; empty_o=1, busy_o=0 by cycle 3.
- Back-to-back pushes with delays 0,3,0 (data A,B,C) -> strobes A@t, B@t+4, C@t+5; level_o counts up then down to 0.
- DEPTH=4, engine held in WAIT by delay 127: push 5 words -> full_o=1 after 4, the 5th gives err_o for one cycle and is never output; remaining 4 are output in order.
- Flush mid-WAIT with 3 queued words -> no further stb_o, level_o=0, empty_o=1, busy_o=0 next cycle; a subsequent delay-0 push strobes normally.
- direct_i 0xBEEF on the same cycle a scheduled strobe of 0x1111 is due -> exactly one stb_o with data_o=0xBEEF; the next queued word follows on schedule.
- Assert rst during WAIT with 2 queued words -> all outputs at reset values immediately (async), no strobe after release, empty_o=1.

Source files
------------

// File: rtl/flobuffer_multi_if.sv
// Handshake/bus bundle for flobuffer_multi: push side, direct/flush controls,
// strobe output and FIFO status.
interface flobuffer_multi_if #(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 7,
    parameter int DEPTH   = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]  data_i;
    logic [DELAY_W-1:0] delay_i;
    logic               valid_i;
    logic               direct_i;
    logic               flush_i;
    logic [DATA_W-1:0]  data_o;
    logic               stb_o;
    logic               empty_o;
    logic               full_o;
    logic               err_o;
    logic [LVL_W-1:0]   level_o;
    logic               busy_o;

    modport master (
        output data_i, delay_i, valid_i, direct_i, flush_i,
        input  data_o, stb_o, empty_o, full_o, err_o, level_o, busy_o
    );

    modport slave (
        input  data_i, delay_i, valid_i, direct_i, flush_i,
        output data_o, stb_o, empty_o, full_o, err_o, level_o, busy_o
    );
endinterface

// File: rtl/flobuffer_multi.sv
// Delay FIFO: queues {delay, data} words and replays each as a one-cycle strobe
// after its programmed delay, with flush, direct bypass and registered status.
module flobuffer_multi #(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 7,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    flobuffer_multi_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int ENT_W = DELAY_W + DATA_W;

    localparam logic [PTR_W-1:0]   PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]   LVL_ONE   = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]   LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]   LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [DELAY_W-1:0] CNT_ONE   = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] CNT_ZERO  = {DELAY_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        WAIT = 2'b10
    } state_t;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]   count_r, count_next_s;
    logic               empty_r, full_r, err_r, busy_r;
    state_t             state_r, state_next_s;
    logic [DELAY_W-1:0] cnt_r, cnt_next_s;
    logic [DATA_W-1:0]  hold_r, hold_next_s;
    logic [DATA_W-1:0]  data_r, fifo_data_s;
    logic               stb_r, fifo_stb_s;
    logic               direct_pend_r;
    logic [DATA_W-1:0]  direct_data_r;
    logic               push_s, pop_s;
    logic [DELAY_W-1:0] head_delay_s;
    logic [DATA_W-1:0]  head_data_s;

    // Rejection is decided on the registered full flag, so a same-cycle pop never rescues a push.
    assign push_s       = bus.valid_i & ~full_r & ~bus.flush_i;
    assign pop_s        = (state_r == LOAD) & (count_r != LVL_ZERO) & ~bus.flush_i;
    assign head_delay_s = mem[rd_ptr_r][ENT_W-1:DATA_W];
    assign head_data_s  = mem[rd_ptr_r][DATA_W-1:0];

    // Occupancy after this edge's push/pop (or flush).
    always_comb begin
        count_next_s = count_r;
        if (bus.flush_i) begin
            count_next_s = LVL_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + LVL_ONE;
                2'b01:   count_next_s = count_r - LVL_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Output engine next-state, delay counter and scheduled strobe.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        hold_next_s  = hold_r;
        fifo_stb_s   = 1'b0;
        fifo_data_s  = hold_r;
        case (state_r)
            IDLE: begin
                if (count_r != LVL_ZERO) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                if (count_r == LVL_ZERO) begin
                    state_next_s = IDLE;
                end else if (head_delay_s == CNT_ZERO) begin
                    fifo_stb_s   = 1'b1;
                    fifo_data_s  = head_data_s;
                    state_next_s = (count_next_s != LVL_ZERO) ? LOAD : IDLE;
                end else begin
                    hold_next_s  = head_data_s;
                    cnt_next_s   = head_delay_s;
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                cnt_next_s = cnt_r - CNT_ONE;
                if (cnt_r <= CNT_ONE) begin
                    fifo_stb_s   = 1'b1;
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = (count_next_s != LVL_ZERO) ? LOAD : IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
        if (bus.flush_i) begin
            state_next_s = IDLE;
            cnt_next_s   = CNT_ZERO;
            fifo_stb_s   = 1'b0;
        end else begin
            fifo_stb_s   = fifo_stb_s;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_r] <= {bus.delay_i, bus.data_i};
        end
    end

    // Pointers, status flags, engine state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= LVL_ZERO;
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
            cnt_r         <= CNT_ZERO;
            hold_r        <= {DATA_W{1'b0}};
            data_r        <= {DATA_W{1'b0}};
            stb_r         <= 1'b0;
            direct_pend_r <= 1'b0;
            direct_data_r <= {DATA_W{1'b0}};
        end else begin
            if (bus.flush_i) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
                if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r       <= count_next_s;
            empty_r       <= (count_next_s == LVL_ZERO);
            full_r        <= (count_next_s == LVL_FULL);
            err_r         <= bus.valid_i & full_r & ~bus.flush_i;
            busy_r        <= (state_next_s != IDLE);
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            hold_r        <= hold_next_s;
            direct_pend_r <= bus.direct_i;
            direct_data_r <= bus.direct_i ? bus.data_i : direct_data_r;
            // The direct value wins a collision; the scheduled word is consumed unseen.
            if (direct_pend_r) begin
                data_r <= direct_data_r;
            end else if (fifo_stb_s) begin
                data_r <= fifo_data_s;
            end else begin
                data_r <= data_r;
            end
            stb_r <= direct_pend_r | fifo_stb_s;
        end
    end

    assign bus.data_o  = data_r;
    assign bus.stb_o   = stb_r;
    assign bus.empty_o = empty_r;
    assign bus.full_o  = full_r;
    assign bus.err_o   = err_r;
    assign bus.level_o = count_r;
    assign bus.busy_o  = busy_r;
endmodule

// File: tb/tb_flobuffer_multi.sv
// Scoreboard bench for flobuffer_multi: directed pushes queue expected
// {data, cycle} strobes; a negedge monitor pops and compares every stb_o.
module tb_flobuffer_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    flobuffer_multi_if #(.DATA_W(16), .DELAY_W(7), .DEPTH(4)) bus ();

    flobuffer_multi #(.DATA_W(16), .DELAY_W(7), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_stb(input logic [15:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic tick(input logic v, input logic [6:0] dl, input logic [15:0] d,
                        input logic dir, input logic fl);
        bus.valid_i  = v;
        bus.delay_i  = dl;
        bus.data_i   = d;
        bus.direct_i = dir;
        bus.flush_i  = fl;
        @(negedge clk);
        bus.valid_i  = 1'b0;
        bus.direct_i = 1'b0;
        bus.flush_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 7'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic status(input string name, input logic [2:0] lvl, input logic emp,
                          input logic ful, input logic bsy);
        check({name, "_level"}, {29'd0, bus.level_o}, {29'd0, lvl});
        check({name, "_empty"}, {31'd0, bus.empty_o}, {31'd0, emp});
        check({name, "_full"},  {31'd0, bus.full_o},  {31'd0, ful});
        check({name, "_busy"},  {31'd0, bus.busy_o},  {31'd0, bsy});
    endtask

    // Monitor: every strobe must match the oldest expected entry in data and cycle.
    always @(negedge clk) begin
        if (bus.stb_o) begin
            if (sb.size() == 0) begin
                check("stb_unexpected", {31'd0, bus.stb_o}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("stb_data", {16'd0, bus.data_o}, {16'd0, mon_e.data});
                check("stb_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        int p;
        bus.valid_i  = 1'b0;
        bus.delay_i  = 7'd0;
        bus.data_i   = 16'h0000;
        bus.direct_i = 1'b0;
        bus.flush_i  = 1'b0;

        // Reset values
        @(negedge clk);
        status("rst", 3'd0, 1'b1, 1'b0, 1'b0);
        check("rst_data", {16'd0, bus.data_o}, 32'd0);
        check("rst_stb", {31'd0, bus.stb_o}, 32'd0);
        check("rst_err", {31'd0, bus.err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Delay-0 single push: strobe two cycles after the push edge
        tick(1'b1, 7'd0, 16'h1234, 1'b0, 1'b0);
        expect_stb(16'h1234, cyc + 2);
        status("t1_push", 3'd1, 1'b0, 1'b0, 1'b0);
        idle(3);
        status("t1_done", 3'd0, 1'b1, 1'b0, 1'b0);

        // Delays 0,3,0 back to back: A@t, B@t+4, C@t+5
        tick(1'b1, 7'd0, 16'h000A, 1'b0, 1'b0);
        p = cyc;
        expect_stb(16'h000A, p + 2);
        expect_stb(16'h000B, p + 6);
        expect_stb(16'h000C, p + 7);
        check("t2_level1", {29'd0, bus.level_o}, 32'd1);
        tick(1'b1, 7'd3, 16'h000B, 1'b0, 1'b0);
        check("t2_level2", {29'd0, bus.level_o}, 32'd2);
        tick(1'b1, 7'd0, 16'h000C, 1'b0, 1'b0);
        check("t2_level3", {29'd0, bus.level_o}, 32'd2);
        idle(8);
        status("t2_done", 3'd0, 1'b1, 1'b0, 1'b0);

        // Overflow while the engine is parked on a max-delay word
        tick(1'b1, 7'd127, 16'h0AAA, 1'b0, 1'b0);
        p = cyc;
        expect_stb(16'h0AAA, p + 129);
        for (int k = 0; k < 4; k++) expect_stb(16'(16'h0B01 + k), p + 131 + 2 * k);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 7'd1, 16'(16'h0B00 + i), 1'b0, 1'b0);
            check("t3_full", {31'd0, bus.full_o}, (i >= 4) ? 32'd1 : 32'd0);
            check("t3_err", {31'd0, bus.err_o}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("t3_level", {29'd0, bus.level_o}, 32'd4);
        idle(1);
        check("t3_err_clear", {31'd0, bus.err_o}, 32'd0);
        idle(140);
        status("t3_done", 3'd0, 1'b1, 1'b0, 1'b0);

        // Flush mid-WAIT with three queued words; a coinciding push is dropped silently
        tick(1'b1, 7'd100, 16'h0C00, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) tick(1'b1, 7'd0, 16'(16'h0C00 + i), 1'b0, 1'b0);
        check("t4_level", {29'd0, bus.level_o}, 32'd3);
        idle(3);
        check("t4_busy", {31'd0, bus.busy_o}, 32'd1);
        tick(1'b1, 7'd0, 16'h0EEE, 1'b0, 1'b1);
        status("t4_flush", 3'd0, 1'b1, 1'b0, 1'b0);
        check("t4_err", {31'd0, bus.err_o}, 32'd0);
        idle(10);
        tick(1'b1, 7'd0, 16'h0D0D, 1'b0, 1'b0);
        expect_stb(16'h0D0D, cyc + 2);
        idle(4);

        // Direct write collides with a scheduled strobe; next word keeps its schedule
        tick(1'b1, 7'd0, 16'h1111, 1'b0, 1'b0);
        p = cyc;
        expect_stb(16'hBEEF, p + 2);
        expect_stb(16'h2222, p + 5);
        tick(1'b0, 7'd0, 16'hBEEF, 1'b1, 1'b0);
        tick(1'b1, 7'd2, 16'h2222, 1'b0, 1'b0);
        idle(6);
        tick(1'b0, 7'd0, 16'h5A5A, 1'b1, 1'b0);
        expect_stb(16'h5A5A, cyc + 1);
        idle(4);
        check("t5_data_held", {16'd0, bus.data_o}, 32'h5A5A);

        // Async reset during WAIT with two words queued
        tick(1'b1, 7'd50, 16'h0E00, 1'b0, 1'b0);
        tick(1'b1, 7'd0, 16'h0E01, 1'b0, 1'b0);
        tick(1'b1, 7'd0, 16'h0E02, 1'b0, 1'b0);
        idle(2);
        check("t6_level_pre", {29'd0, bus.level_o}, 32'd2);
        #2 rst = 1'b1;
        #1;
        status("t6_async", 3'd0, 1'b1, 1'b0, 1'b0);
        check("t6_data", {16'd0, bus.data_o}, 32'd0);
        check("t6_stb", {31'd0, bus.stb_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(60);
        status("t6_done", 3'd0, 1'b1, 1'b0, 1'b0);

        check("missing_strobes", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
